// File: rtl/t5_dwb_ram.sv
// ---------------------------------------------------------------------------
// t5_dwb_ram -- Wishbone-style data-bus responder around a 2^AW x 32 RAM.
//
// A request is accepted in IDLE when dwb_stb is high. The address, write
// data, byte select and direction are latched at that edge. After WAIT
// wait states the block raises dwb_ack for one cycle. Reads present the
// whole addressed word on dwb_dti during the ack cycle, and dwb_dti keeps
// that word until the next read ack. Writes update the selected byte
// lanes at the end of the ack cycle. Dropping dwb_stb while in wait states
// aborts the transfer.
//
// Parameters:
//   XLEN  data width (only 32 is supported)
//   AW    word-address bits; memory depth is 2^AW words
//   WAIT  wait states before the acknowledge (0..15)
//
// Ports:
//   sys_clk  in   clock; all state changes on the rising edge
//   sys_rst  in   asynchronous active-high reset
//   dwb_adr  in   word address [31:2]; only [AW+1:2] is decoded
//   dwb_dto  in   write data
//   dwb_sel  in   byte-lane select
//   dwb_stb  in   request strobe
//   dwb_wre  in   1 = write, 0 = read
//   dwb_ack  out  one-cycle transfer acknowledge
//   dwb_dti  out  read data
//   dwb_err  out  illegal-select flag, qualified by dwb_ack
//
// Optional feature: define T5_DWB_ERR_EN to reject illegal byte selects.
// A rejected transfer is still acknowledged, but its write is suppressed,
// a read returns 0, and dwb_err is raised for that ack cycle.
// Without the macro, dwb_err is tied to 0 and any select is honoured.
// ---------------------------------------------------------------------------
module t5_dwb_ram #(
    parameter int XLEN = 32,
    parameter int AW   = 10,
    parameter int WAIT = 0
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    input  logic [31:2]     dwb_adr,
    input  logic [XLEN-1:0] dwb_dto,
    input  logic [3:0]      dwb_sel,
    input  logic            dwb_stb,
    input  logic            dwb_wre,
    output logic            dwb_ack,
    output logic [XLEN-1:0] dwb_dti,
    output logic            dwb_err
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t          state, state_nx;
    logic [3:0]      cnt, cnt_nx;
    logic            accept;     // latch the request at this edge
    logic            enter_ack;  // capture read data at this edge

    logic [AW-1:0]   adr_q;
    logic [XLEN-1:0] dto_q;
    logic [3:0]      sel_q;
    logic            wre_q;

    logic [XLEN-1:0] mem [2**AW];

    // With WAIT=0 the ack state is entered on the same edge that accepts
    // the request, so the read address must come from the bus directly.
    logic [AW-1:0]   cur_idx;
    logic            cur_wre;
    logic            rd_block;
    logic            wr_block;

    logic            unused_adr;
    assign unused_adr = ^dwb_adr[31:AW+2];

    assign cur_idx = (state == S_IDLE) ? dwb_adr[AW+1:2] : adr_q;
    assign cur_wre = (state == S_IDLE) ? dwb_wre : wre_q;

`ifdef T5_DWB_ERR_EN
    logic [3:0] cur_sel;

    function automatic logic legal_sel(input logic [3:0] s);
        return s inside {4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};
    endfunction

    assign cur_sel  = (state == S_IDLE) ? dwb_sel : sel_q;
    assign rd_block = !legal_sel(cur_sel);
    assign wr_block = !legal_sel(sel_q);
    assign dwb_err  = (state == S_ACK) && wr_block;
`else
    assign rd_block = 1'b0;
    assign wr_block = 1'b0;
    assign dwb_err  = 1'b0;
`endif

    // Decoded straight from the state register, so an asynchronous reset
    // removes the ack at once, without waiting for a clock edge.
    assign dwb_ack = (state == S_ACK);

    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_nx  = state;
        cnt_nx    = cnt;
        accept    = 1'b0;
        enter_ack = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (dwb_stb) begin
                    accept = 1'b1;
                    if (WAIT == 0) begin
                        state_nx  = S_ACK;
                        enter_ack = 1'b1;
                    end else begin
                        cnt_nx   = 4'(WAIT - 1);
                        state_nx = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!dwb_stb) begin
                    state_nx = S_IDLE;
                    cnt_nx   = 4'd0;
                end else if (cnt == 4'd0) begin
                    state_nx  = S_ACK;
                    enter_ack = 1'b1;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            S_ACK:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            adr_q   <= '0;
            dto_q   <= '0;
            sel_q   <= 4'd0;
            wre_q   <= 1'b0;
            dwb_dti <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept) begin
                adr_q <= dwb_adr[AW+1:2];
                dto_q <= dwb_dto;
                sel_q <= dwb_sel;
                wre_q <= dwb_wre;
            end
            if (enter_ack && !cur_wre) begin
                dwb_dti <= rd_block ? '0 : mem[cur_idx];
            end
        end
    end

    // NOTE: the memory array has no reset. Its contents survive sys_rst,
    // and it can still map onto plain RAM. A reset that hits during the ack
    // cycle forces the state to IDLE first, which suppresses the write.
    always_ff @(posedge sys_clk) begin
        if (state == S_ACK && wre_q && !wr_block) begin
            for (int i = 0; i < 4; i++) begin
                if (sel_q[i]) begin
                    mem[adr_q][8*i +: 8] <= dto_q[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_t5_dwb_ram.sv
// ---------------------------------------------------------------------------
// tb_t5_dwb_ram -- directed bench for t5_dwb_ram.
// Two instances share the clock and reset: u0 uses WAIT=0 and u3 uses
// WAIT=3. Each instance has its own bus signals. The driver keeps a
// word-level model of each memory and records when each ack is due. A
// compare process checks ack, err and dti for both instances on every
// cycle. Directed reads also carry literal expected values.
// ---------------------------------------------------------------------------
module tb_t5_dwb_ram;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [29:0] adr [2];
    logic [31:0] dto [2];
    logic [3:0]  sel [2];
    logic        stb [2];
    logic        wre [2];
    logic        ack [2];
    logic [31:0] dti [2];
    logic        err [2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // model state
    logic [31:0] mm [2][1024];
    int          m_ack_at [2];
    logic        m_rd     [2];
    logic        m_perr   [2];
    logic [31:0] m_pend   [2];
    logic [31:0] m_dti    [2];

    t5_dwb_ram #(.XLEN(32), .AW(10), .WAIT(0)) u0 (
        .sys_clk(clk), .sys_rst(rst), .dwb_adr(adr[0]), .dwb_dto(dto[0]),
        .dwb_sel(sel[0]), .dwb_stb(stb[0]), .dwb_wre(wre[0]),
        .dwb_ack(ack[0]), .dwb_dti(dti[0]), .dwb_err(err[0])
    );

    t5_dwb_ram #(.XLEN(32), .AW(10), .WAIT(3)) u3 (
        .sys_clk(clk), .sys_rst(rst), .dwb_adr(adr[1]), .dwb_dto(dto[1]),
        .dwb_sel(sel[1]), .dwb_stb(stb[1]), .dwb_wre(wre[1]),
        .dwb_ack(ack[1]), .dwb_dti(dti[1]), .dwb_err(err[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic legal(input logic [3:0] s);
        return s inside {4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};
    endfunction

    function automatic logic err_model(input logic [3:0] s);
`ifdef T5_DWB_ERR_EN
        return !legal(s);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = data[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] rd_model(input int d, input logic [9:0] idx, input logic [3:0] s);
        return err_model(s) ? 32'h0 : mm[d][idx];
    endfunction

    task automatic clear_model();
        for (int d = 0; d < 2; d++) begin
            m_ack_at[d] = -1;
            m_dti[d]    = 32'h0;
        end
    endtask

    // Compare process: sample 1 time unit after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            for (int d = 0; d < 2; d++) begin
                logic exp_ack;
                exp_ack = (cyc == m_ack_at[d]);
                if (exp_ack && m_rd[d]) m_dti[d] = m_pend[d];
                check($sformatf("ack%0d", d), 32'(ack[d]), 32'(exp_ack));
                check($sformatf("err%0d", d), 32'(err[d]), 32'(exp_ack && m_perr[d]));
                check($sformatf("dti%0d", d), dti[d], m_dti[d]);
            end
        end
    end

    task automatic wait_until(input int target);
        int k;
        k = 0;
        while (cyc < target && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (cyc < target) check("timeout", 32'(cyc), 32'(target));
    endtask

    // mode 0: normal; 1: drop stb after 2 cycles; 2: reset during wait; 3: reset during ack
    task automatic xfer(input int d, input logic [31:0] baddr, input logic [31:0] data,
                        input logic [3:0] s, input logic w, input int mode,
                        input logic lit_en, input logic [31:0] lit);
        int         e, wt;
        logic [9:0] idx;
        wt  = (d == 1) ? 3 : 0;
        idx = baddr[11:2];
        @(negedge clk);
        adr[d] = baddr[31:2];
        dto[d] = data;
        sel[d] = s;
        wre[d] = w;
        stb[d] = 1'b1;
        e = cyc + 1;
        if (mode == 0 || mode == 3) begin
            m_ack_at[d] = e + wt;
            m_rd[d]     = !w;
            m_pend[d]   = rd_model(d, idx, s);
            m_perr[d]   = err_model(s);
            wait_until(e + wt);
            if (lit_en) check($sformatf("lit%0d@%h", d, baddr), dti[d], lit);
            if (mode == 3) begin
                check("ack_before_rst", 32'(ack[d]), 32'd1);
                rst = 1'b1;
                #1;
                check("ack_async_drop", 32'(ack[d]), 32'd0);
                clear_model();
                stb[d] = 1'b0;
                repeat (2) @(negedge clk);
                rst = 1'b0;
            end else begin
                // Scramble the bus during ack; the latched request must win.
                stb[d] = 1'b0;
                adr[d] = ~adr[d];
                dto[d] = ~dto[d];
                sel[d] = 4'hF;
                wre[d] = ~w;
                if (w && !err_model(s)) mm[d][idx] = merge(mm[d][idx], data, s);
            end
        end else begin
            m_ack_at[d] = -1;
            wait_until(e + 1);
            if (mode == 2) begin
                #2;
                rst = 1'b1;
                #1;
                check("ack_in_rst", 32'(ack[d]), 32'd0);
                clear_model();
                stb[d] = 1'b0;
                repeat (2) @(negedge clk);
                rst = 1'b0;
            end else begin
                stb[d] = 1'b0;
                repeat (wt) @(negedge clk);
            end
        end
    endtask

    logic [31:0] exp_sel5;
    logic [31:0] exp_sel6;

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            adr[d] = '0; dto[d] = '0; sel[d] = '0; stb[d] = 1'b0; wre[d] = 1'b0;
            m_rd[d] = 1'b0; m_perr[d] = 1'b0; m_pend[d] = '0;
        end
        clear_model();
        repeat (2) @(negedge clk);
        check("rst_ack", 32'(ack[0]), 32'd0);
        check("rst_dti", dti[0], 32'h0);
        check("rst_err", 32'(err[1]), 32'd0);
        rst = 1'b0;

        // WAIT=0 instance: basic write/read, byte lanes, wrap, select legality
        xfer(0, 32'h100,  32'h11223344, 4'hF, 1'b1, 0, 1'b0, 32'h0);
        xfer(0, 32'h100,  32'h0,        4'hF, 1'b0, 0, 1'b1, 32'h11223344);
        xfer(0, 32'h200,  32'hAABBCCDD, 4'hF, 1'b1, 0, 1'b0, 32'h0);
        xfer(0, 32'h200,  32'h00005500, 4'h2, 1'b1, 0, 1'b0, 32'h0);
        xfer(0, 32'h200,  32'h0,        4'hF, 1'b0, 0, 1'b1, 32'hAABB55DD);
        xfer(0, 32'h200,  32'h12340000, 4'hC, 1'b1, 0, 1'b0, 32'h0);
        xfer(0, 32'h200,  32'h0,        4'hF, 1'b0, 0, 1'b1, 32'h123455DD);
        xfer(0, 32'h200,  32'h0,        4'h1, 1'b0, 0, 1'b1, 32'h123455DD);
        xfer(0, 32'h1000, 32'hCAFE0001, 4'hF, 1'b1, 0, 1'b0, 32'h0);
        xfer(0, 32'h0000, 32'h0,        4'hF, 1'b0, 0, 1'b1, 32'hCAFE0001);
        xfer(0, 32'h300,  32'h01020304, 4'hF, 1'b1, 0, 1'b0, 32'h0);
        xfer(0, 32'h300,  32'hA0B0C0D0, 4'h5, 1'b1, 0, 1'b0, 32'h0);
`ifdef T5_DWB_ERR_EN
        exp_sel5 = 32'h01020304;
        exp_sel6 = 32'h0;
`else
        exp_sel5 = 32'h01B003D0;
        exp_sel6 = 32'h01B003D0;
`endif
        xfer(0, 32'h300,  32'h0,        4'hF, 1'b0, 0, 1'b1, exp_sel5);
        xfer(0, 32'h300,  32'h0,        4'h6, 1'b0, 0, 1'b1, exp_sel6);

        // WAIT=3 instance: latency, abort, asynchronous reset
        xfer(1, 32'h40, 32'hDEADBEEF, 4'hF, 1'b1, 0, 1'b0, 32'h0);
        xfer(1, 32'h40, 32'h0,        4'hF, 1'b0, 0, 1'b1, 32'hDEADBEEF);
        xfer(1, 32'h40, 32'h00000000, 4'hF, 1'b1, 1, 1'b0, 32'h0);
        xfer(1, 32'h40, 32'h0,        4'hF, 1'b0, 0, 1'b1, 32'hDEADBEEF);
        xfer(1, 32'h40, 32'h55555555, 4'hF, 1'b1, 2, 1'b0, 32'h0);
        xfer(1, 32'h40, 32'h0,        4'hF, 1'b0, 0, 1'b1, 32'hDEADBEEF);
        xfer(1, 32'h44, 32'h0F0F0F0F, 4'hF, 1'b1, 0, 1'b0, 32'h0);
        xfer(1, 32'h44, 32'hFFFFFFFF, 4'hF, 1'b1, 3, 1'b0, 32'h0);
        xfer(1, 32'h44, 32'h0,        4'hF, 1'b0, 0, 1'b1, 32'h0F0F0F0F);
        xfer(1, 32'h44, 32'h0000A500, 4'h2, 1'b1, 0, 1'b0, 32'h0);
        xfer(1, 32'h44, 32'h0,        4'hF, 1'b0, 0, 1'b1, 32'h0F0FA50F);

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
